// File: rtl/micro86_sram.sv
// micro86 byte-bus responder: each processor byte access becomes one 16-bit SRAM cycle.
// Define MICRO86_SRAM_RDBUF_EN to build the one-word read buffer (zero-latency repeat reads).
module micro86_sram #(
  parameter int unsigned WAIT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] a,
  input  logic [7:0]  o,
  input  logic        w,
  output logic [7:0]  i,
  output logic        ce,
  output logic [18:0] sram_a,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic        ce_q, ce_d;
  logic [7:0]  i_q, i_d;
  logic [18:0] sa_q, sa_d;
  logic [15:0] dq_q, dq_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;

  logic        hit_s;
  logic [7:0]  hit_byte_s;
  logic [7:0]  rd_byte_s;

  assign rd_byte_s = sel_q ? sram_dq_i[15:8] : sram_dq_i[7:0];

  // Next-state and next-output logic; all SRAM pins are driven from registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    ce_d    = 1'b0;
    i_d     = i_q;
    sa_d    = sa_q;
    dq_d    = dq_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    lb_n_d  = lb_n_q;
    ub_n_d  = ub_n_q;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          i_d = hit_byte_s;
        end else begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          sel_d   = a[0];
          wr_d    = w;
          sa_d    = a[19:1];
          dq_d    = {o, o};
          dq_oe_d = w;
          ce_n_d  = 1'b0;
          oe_n_d  = w;
          we_n_d  = 1'b1;
          lb_n_d  = a[0];
          ub_n_d  = ~a[0];
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ce_d    = 1'b1;
          dq_oe_d = 1'b0;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          if (!wr_q) begin
            i_d = rd_byte_s;
          end else begin
            i_d = i_q;
          end
        end else begin
          // First ACCESS cycle keeps we_n high for address setup.
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~wr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset forces the SRAM idle immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      ce_q    <= 1'b0;
      i_q     <= 8'h00;
      sa_q    <= 19'd0;
      dq_q    <= 16'h0000;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      ce_q    <= ce_d;
      i_q     <= i_d;
      sa_q    <= sa_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
    end
  end

  assign sram_a     = sa_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

`ifdef MICRO86_SRAM_RDBUF_EN
  logic [18:0] tag_q;
  logic [15:0] data_q;
  logic        valid_q;

  assign hit_s      = (state_q == IDLE) && !w && valid_q && (a[19:1] == tag_q);
  assign hit_byte_s = a[0] ? data_q[15:8] : data_q[7:0];

  // Buffer fill on completed reads; writes to the buffered word patch the matching byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q   <= 19'd0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else if ((state_q == ACCESS) && (cnt_q == 4'd0) && !wr_q) begin
      tag_q   <= sa_q;
      data_q  <= sram_dq_i;
      valid_q <= 1'b1;
    end else if ((state_q == DONE) && wr_q && valid_q && (sa_q == tag_q)) begin
      if (sel_q) begin
        data_q[15:8] <= dq_q[15:8];
      end else begin
        data_q[7:0] <= dq_q[7:0];
      end
    end else begin
      valid_q <= valid_q;
    end
  end

  assign ce = ce_q | hit_s;
  assign i  = hit_s ? hit_byte_s : i_q;
`else
  assign hit_s      = 1'b0;
  assign hit_byte_s = 8'h00;
  assign ce         = ce_q;
  assign i          = i_q;
`endif

endmodule

// File: tb/tb_micro86_sram.sv
// Bench for micro86_sram: directed byte accesses against a behavioural SRAM; a monitor
// pops the expected response on every ce pulse and checks data, latency and bus activity.
`timescale 1ns/1ps
module tb_micro86_sram;

  localparam int WAIT_P = 2;
`ifdef MICRO86_SRAM_RDBUF_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] a       = 20'h00000;
  logic [7:0]  o       = 8'h00;
  logic        w       = 1'b0;
  logic [7:0]  i;
  logic        ce;
  logic [18:0] sram_a;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  micro86_sram #(.WAIT(WAIT_P)) dut (
    .clock(clock), .reset_n(reset_n), .a(a), .o(o), .w(w), .i(i), .ce(ce),
    .sram_a(sram_a), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural SRAM: write on a clock edge while selected with we_n low.
  logic [15:0] mem [0:524287];
  bit init_done = 1'b0;
  always @(posedge clock) begin
    if (!init_done) begin
      mem[19'h00012] <= 16'hBEEF;
      mem[19'h00180] <= 16'h1234;
      init_done <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
    end
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'h0000;

  typedef struct {
    string       name;
    logic        rd;
    logic [7:0]  exp_i;
    int          exp_lat;
    int          exp_acc;
    int          exp_we;
    logic [18:0] exp_sa;
    logic        exp_lb_n;
    logic        exp_ub_n;
    logic [15:0] exp_dq;
    int          pcyc;
  } item_t;

  item_t sb[$];
  item_t mit;
  int    errors = 0;
  int    checks = 0;
  bit    end_req = 1'b0;
  bit    end_done = 1'b0;

  int          acc_cnt = 0, we_cnt = 0, lat;
  logic [18:0] rec_sa;
  logic        rec_lb, rec_ub, rec_we1;
  logic [15:0] rec_dq;
  bit          stable = 1'b1, dqoe_all = 1'b1, dqoe_any = 1'b0, oe_lo_all = 1'b1, oe_lo_any = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    acc_cnt = 0; we_cnt = 0; stable = 1'b1;
    dqoe_all = 1'b1; dqoe_any = 1'b0; oe_lo_all = 1'b1; oe_lo_any = 1'b0;
  endtask

  // Monitor: watch the SRAM bus, and score each ce pulse against the queue head.
  always @(negedge clock) begin
    if (!reset_n) begin
      check("reset ce", ce, 32'd0);
      check("reset i", i, 32'd0);
      check("reset strobes ce/oe/we/lb/ub", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      check("reset dq_oe", sram_dq_oe, 32'd0);
      check("reset sram_a", sram_a, 32'd0);
      check("reset dq_o", sram_dq_o, 32'd0);
      clear_stats();
    end else begin
      if (!sram_ce_n) begin
        if (acc_cnt == 0) begin
          rec_sa = sram_a; rec_lb = sram_lb_n; rec_ub = sram_ub_n; rec_dq = sram_dq_o; rec_we1 = sram_we_n;
        end else if (sram_a !== rec_sa || sram_lb_n !== rec_lb || sram_ub_n !== rec_ub || sram_dq_o !== rec_dq) begin
          stable = 1'b0;
        end
        acc_cnt++;
        if (!sram_we_n) we_cnt++;
        dqoe_all  = dqoe_all & sram_dq_oe;
        dqoe_any  = dqoe_any | sram_dq_oe;
        oe_lo_all = oe_lo_all & !sram_oe_n;
        oe_lo_any = oe_lo_any | !sram_oe_n;
      end
      if (ce) begin
        check("ce with transaction pending", (sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mit = sb.pop_front();
          lat = cyc - mit.pcyc + 1;
          check({mit.name, " i"}, i, mit.exp_i);
          check({mit.name, " latency"}, lat, mit.exp_lat);
          check({mit.name, " access cycles"}, acc_cnt, mit.exp_acc);
          check({mit.name, " we_n low cycles"}, we_cnt, mit.exp_we);
          if (mit.exp_acc > 0) begin
            check({mit.name, " sram_a"}, rec_sa, mit.exp_sa);
            check({mit.name, " lanes lb/ub"}, {rec_lb, rec_ub}, {mit.exp_lb_n, mit.exp_ub_n});
            check({mit.name, " bus stable"}, stable, 32'd1);
            if (mit.rd) begin
              check({mit.name, " read dq_oe/oe"}, {dqoe_any, oe_lo_all}, 32'd1);
            end else begin
              check({mit.name, " write dq_oe/oe"}, {dqoe_all, oe_lo_any}, 32'd2);
              check({mit.name, " dq_o"}, rec_dq, mit.exp_dq);
              check({mit.name, " we_n first cycle"}, rec_we1, 32'd1);
            end
          end
        end
        clear_stats();
      end
    end
    if (end_req && !end_done) begin
      check("scoreboard drained", sb.size(), 32'd0);
      end_done = 1'b1;
    end
  end

  task automatic do_access(input string nm, input logic [19:0] addr, input logic [7:0] d,
                           input logic wr, input logic hit, input logic [7:0] exp_i);
    item_t it;
    bit    seen;
    a = addr; o = d; w = wr;
    it.name     = nm;
    it.rd       = !wr;
    it.exp_i    = exp_i;
    it.exp_lat  = hit ? 1 : WAIT_P + 2;
    it.exp_acc  = hit ? 0 : WAIT_P;
    it.exp_we   = (hit || !wr) ? 0 : WAIT_P - 1;
    it.exp_sa   = addr[19:1];
    it.exp_lb_n = addr[0];
    it.exp_ub_n = !addr[0];
    it.exp_dq   = {d, d};
    it.pcyc     = cyc;
    sb.push_back(it);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      seen = ce;
    end
    if (!seen) begin
      $display("FAIL %s timeout: got no ce, expected ce within 20 cycles", nm);
      $fatal(1, "stalled");
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    do_access("rd 00025 miss",   20'h00025, 8'h00, 1'b0, 1'b0,   8'hBE);
    do_access("wr 00100",        20'h00100, 8'h5A, 1'b1, 1'b0,   8'hBE);
    do_access("rd 00100",        20'h00100, 8'h00, 1'b0, 1'b0,   8'h5A);
    do_access("rd 00024",        20'h00024, 8'h00, 1'b0, 1'b0,   8'hEF);
    do_access("rd 00025 repeat", 20'h00025, 8'h00, 1'b0, BUF_ON, 8'hBE);
    do_access("wr 00025",        20'h00025, 8'h11, 1'b1, 1'b0,   8'hBE);
    do_access("rd 00025 coh",    20'h00025, 8'h00, 1'b0, BUF_ON, 8'h11);
    do_access("rd 00024 coh",    20'h00024, 8'h00, 1'b0, BUF_ON, 8'hEF);
    // Write to 0x00300 cut off by reset in its second ACCESS cycle.
    a = 20'h00300; o = 8'h77; w = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    w = 1'b0;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    do_access("rd 00024 post-reset", 20'h00024, 8'h00, 1'b0, 1'b0, 8'hEF);
    do_access("rd 00300 post-reset", 20'h00300, 8'h00, 1'b0, 1'b0, 8'h34);
    end_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
